// File: rtl/timer_scheduler.sv
// timer_scheduler: NUM_CH millisecond timeout channels sharing one prescaler,
// with expiries reported one per handshake through a round-robin event port.
module timer_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CLKS_PER_MS = 50000,
    parameter int DUR_W       = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH*DUR_W-1:0]   dur,
    input  logic [NUM_CH-1:0]         cancel,
    output logic [NUM_CH-1:0]         busy,
    output logic                      evt_valid,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    input  logic                      evt_ready,
    output logic                      tick
);
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} ch_state_e;

    ch_state_e         st_q  [NUM_CH];
    logic [DUR_W-1:0]  rem_q [NUM_CH];
    logic [PW-1:0]     presc_q;
    logic              tick_q;
    logic [CW-1:0]     rr_q;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] expd;
    logic [CW-1:0]     cand;
    logic              hs;

    assign busy = busy_q;
    assign tick = tick_q;
    assign hs   = evt_valid && evt_ready;

    always_comb begin
        expd = '0;
        for (int i = 0; i < NUM_CH; i++) expd[i] = (st_q[i] == EXPIRED);
    end

    // Walk from farthest to nearest so the channel closest after rr_q wins.
    always_comb begin
        evt_valid = 1'b0;
        evt_ch    = '0;
        cand      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CW'((int'(rr_q) + k) % NUM_CH);
            if (expd[cand]) begin
                evt_valid = 1'b1;
                evt_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            rr_q    <= CW'(NUM_CH - 1);
            busy_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= IDLE;
                rem_q[i] <= '0;
            end
        end else begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            tick_q  <= (presc_q == PRESC_MAX);
            if (hs) rr_q <= evt_ch;
            // Priority per channel: cancel, start, accept, countdown.
            for (int i = 0; i < NUM_CH; i++) begin
                if (cancel[i]) begin
                    st_q[i]   <= IDLE;
                    rem_q[i]  <= '0;
                    busy_q[i] <= 1'b0;
                end else if (start[i]) begin
                    rem_q[i]  <= dur[i*DUR_W +: DUR_W];
                    st_q[i]   <= (dur[i*DUR_W +: DUR_W] == '0) ? EXPIRED : RUN;
                    busy_q[i] <= 1'b1;
                end else if (hs && evt_ch == CW'(i)) begin
                    st_q[i]   <= IDLE;
                    busy_q[i] <= 1'b0;
                end else if (st_q[i] == RUN && tick_q) begin
                    st_q[i]  <= (rem_q[i] == DUR_W'(1)) ? EXPIRED : RUN;
                    rem_q[i] <= (rem_q[i] == DUR_W'(1)) ? '0 : rem_q[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed and randomized checks of timer_scheduler against
// a deadline-based reference model (absolute expiry cycle per channel).
module tb_timer_scheduler;
    localparam int C  = 4;
    localparam int NC = 4;
    localparam int DW = 12;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NC-1:0]   start = '0;
    logic [NC*DW-1:0] dur = '0;
    logic [NC-1:0]   cancel = '0;
    logic [NC-1:0]   busy;
    logic            evt_valid;
    logic [1:0]      evt_ch;
    logic            evt_ready = 1'b0;
    logic            tick;

    int n_checks = 0;
    int n_fail = 0;
    int ecnt = 0;
    int m_st [NC];
    int m_exp_at [NC];
    int m_rr = NC - 1;

    timer_scheduler #(.NUM_CH(NC), .CLKS_PER_MS(C), .DUR_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .dur(dur), .cancel(cancel),
        .busy(busy), .evt_valid(evt_valid), .evt_ch(evt_ch),
        .evt_ready(evt_ready), .tick(tick)
    );

    always #5 clk = ~clk;

    // Channels count down on the edges right after each tick pulse: edges k*C+1, k>=1.
    function automatic int first_dec(input int s);
        return ((s - 1) / C + 1) * C + 1;
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (m_rr + k) % NC;
            if (m_st[c] == 2) return c;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] m_busy();
        logic [NC-1:0] b;
        for (int i = 0; i < NC; i++) b[i] = (m_st[i] != 0);
        return b;
    endfunction

    function automatic bit tick_exp();
        return (ecnt >= C) && (ecnt % C == 0);
    endfunction

    task automatic set_dur(input int ch, input int d);
        dur[ch*DW +: DW] = DW'(d);
    endtask

    // One clock edge; model advanced with the inputs sampled at that edge.
    task automatic cycle();
        int pk;
        bit hs;
        pk = m_pick();
        hs = (pk >= 0) && evt_ready;
        @(posedge clk);
        if (reset) begin
            ecnt = 0;
            m_rr = NC - 1;
            for (int i = 0; i < NC; i++) m_st[i] = 0;
        end else begin
            ecnt++;
            if (hs) m_rr = pk;
            for (int i = 0; i < NC; i++) begin
                int d;
                d = int'(dur[i*DW +: DW]);
                if (cancel[i]) m_st[i] = 0;
                else if (start[i]) begin
                    m_st[i] = (d == 0) ? 2 : 1;
                    m_exp_at[i] = first_dec(ecnt) + (d - 1) * C;
                end else if (hs && pk == i) m_st[i] = 0;
                else if (m_st[i] == 1 && m_exp_at[i] == ecnt) m_st[i] = 2;
            end
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        n_checks++; if (evt_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", evt_ch); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
        reset = 1'b0;
        for (int n = 0; n < 3 * C + 1; n++) begin
            cycle();
            n_checks++; if (tick !== tick_exp()) begin n_fail++; $display("FAIL tick_phase: cycle %0d got %b want %b", ecnt, tick, tick_exp()); end
        end
    endtask

    task automatic test_single();
        int s, lat;
        evt_ready = 1'b1;
        set_dur(0, 3);
        start = 4'b0001;
        cycle();
        s = ecnt;
        start = '0;
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy[0]); end
        for (int n = 0; n < 20 && !evt_valid; n++) cycle();
        lat = ecnt - s;
        n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got valid %b want 1", evt_valid); end
        n_checks++; if (evt_ch !== 2'd0) begin n_fail++; $display("FAIL single_ch: got %0d want 0", evt_ch); end
        n_checks++; if (lat < 2 * C + 1 || lat > 3 * C + 1) begin n_fail++; $display("FAIL single_latency: got %0d want 9..13", lat); end
        n_checks++; if (ecnt !== m_exp_at[0]) begin n_fail++; $display("FAIL single_exp_cycle: got %0d want %0d", ecnt, m_exp_at[0]); end
        cycle();
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy[0]); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b want 0", evt_valid); end
    endtask

    task automatic test_stall();
        pulse_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_dur(i, 2);
        start = 4'b0111;
        cycle();
        start = '0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            n_checks++; if (evt_valid !== (m_pick() >= 0)) begin n_fail++; $display("FAIL stall_valid: cycle %0d got %b want %b", ecnt, evt_valid, m_pick() >= 0); end
            if (evt_valid) begin
                n_checks++; if (evt_ch !== 2'd0) begin n_fail++; $display("FAIL stall_hold: got %0d want 0", evt_ch); end
            end
        end
        n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pending: got %b want 1", evt_valid); end
        evt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'(k)) begin n_fail++; $display("FAIL drain_order: got valid %b ch %0d want 1 ch %0d", evt_valid, evt_ch, k); end
            cycle();
        end
        n_checks++; if (evt_valid !== 1'b0 || busy !== 4'b0) begin n_fail++; $display("FAIL drain_empty: got valid %b busy %b want 0 0000", evt_valid, busy); end
    endtask

    task automatic test_rr();
        evt_ready = 1'b1;
        set_dur(1, 0);
        start = 4'b0010;
        cycle();
        start = '0;
        n_checks++; if (evt_ch !== 2'd1) begin n_fail++; $display("FAIL rr_grant1: got %0d want 1", evt_ch); end
        cycle();
        evt_ready = 1'b0;
        set_dur(0, 1);
        set_dur(2, 1);
        start = 4'b0101;
        cycle();
        start = '0;
        for (int n = 0; n < 2 * C + 2 && !evt_valid; n++) cycle();
        n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin n_fail++; $display("FAIL rr_first: got valid %b ch %0d want 1 ch 2", evt_valid, evt_ch); end
        evt_ready = 1'b1;
        cycle();
        n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin n_fail++; $display("FAIL rr_second: got valid %b ch %0d want 1 ch 0", evt_valid, evt_ch); end
        cycle();
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_empty: got %b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_zero_dur();
        set_dur(3, 0);
        start = 4'b1000;
        cycle();
        start = '0;
        n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin n_fail++; $display("FAIL zero_dur: got valid %b ch %0d want 1 ch 3", evt_valid, evt_ch); end
        evt_ready = 1'b1;
        cycle();
        n_checks++; if (evt_valid !== 1'b0 || busy !== 4'b0) begin n_fail++; $display("FAIL zero_dur_ack: got valid %b busy %b want 0 0000", evt_valid, busy); end
        evt_ready = 1'b0;
    endtask

    task automatic test_cancel();
        int ticks;
        set_dur(1, 5);
        start = 4'b0010;
        cycle();
        start = '0;
        ticks = 0;
        for (int n = 0; n < 4 * C && ticks < 2; n++) begin
            cycle();
            if (tick) ticks++;
        end
        n_checks++; if (ticks !== 2 || busy[1] !== 1'b1) begin n_fail++; $display("FAIL cancel_setup: got ticks %0d busy %b want 2 1", ticks, busy[1]); end
        cancel = 4'b0010;
        cycle();
        cancel = '0;
        n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", busy[1]); end
        for (int n = 0; n < 6 * C; n++) begin
            cycle();
            n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_no_event: cycle %0d got %b want 0", ecnt, evt_valid); end
        end
        set_dur(2, 2);
        start = 4'b0100;
        cancel = 4'b0100;
        cycle();
        start = '0;
        cancel = '0;
        for (int n = 0; n < 3 * C; n++) begin
            n_checks++; if (busy !== 4'b0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL start_cancel: got busy %b valid %b want 0000 0", busy, evt_valid); end
            cycle();
        end
        set_dur(3, 0);
        start = 4'b1000;
        cycle();
        start = '0;
        n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL withdraw_setup: got %b want 1", evt_valid); end
        cancel = 4'b1000;
        cycle();
        cancel = '0;
        n_checks++; if (evt_valid !== 1'b0 || busy[3] !== 1'b0) begin n_fail++; $display("FAIL withdraw: got valid %b busy %b want 0 0", evt_valid, busy[3]); end
    endtask

    task automatic test_restart();
        int old, s, lat;
        evt_ready = 1'b1;
        set_dur(0, 2);
        start = 4'b0001;
        cycle();
        start = '0;
        old = m_exp_at[0];
        for (int n = 0; n < 4 * C && ecnt < old - 2; n++) cycle();
        set_dur(0, 4);
        start = 4'b0001;
        cycle();
        s = ecnt;
        start = '0;
        for (int n = 0; n < 5 * C + 2 && !evt_valid; n++) cycle();
        lat = ecnt - s;
        n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin n_fail++; $display("FAIL restart_event: got valid %b ch %0d want 1 ch 0", evt_valid, evt_ch); end
        n_checks++; if (ecnt !== old + 3 * C) begin n_fail++; $display("FAIL restart_time: got cycle %0d want %0d", ecnt, old + 3 * C); end
        n_checks++; if (lat < 3 * C + 1 || lat > 4 * C + 1) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d..%0d", lat, 3 * C + 1, 4 * C + 1); end
        cycle();
        evt_ready = 1'b0;
        set_dur(2, 0);
        start = 4'b0100;
        cycle();
        set_dur(2, 1);
        cycle();
        start = '0;
        n_checks++; if (evt_valid !== 1'b0 || busy[2] !== 1'b1) begin n_fail++; $display("FAIL restart_expired: got valid %b busy %b want 0 1", evt_valid, busy[2]); end
        for (int n = 0; n < 2 * C + 2 && !evt_valid; n++) cycle();
        n_checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin n_fail++; $display("FAIL restart_expired_event: got valid %b ch %0d want 1 ch 2", evt_valid, evt_ch); end
        evt_ready = 1'b1;
        cycle();
        set_dur(1, 3);
        start = 4'b0010;
        cycle();
        start = '0;
        for (int n = 0; n < 5; n++) cycle();
        reset = 1'b1;
        cycle();
        n_checks++; if (busy !== 4'b0 || evt_valid !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL midreset: got busy %b valid %b tick %b want 0000 0 0", busy, evt_valid, tick); end
        reset = 1'b0;
        for (int n = 0; n < 4 * C; n++) begin
            cycle();
            n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_event: cycle %0d got %b want 0", ecnt, evt_valid); end
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 600; n++) begin
            int pk;
            evt_ready = 1'($urandom % 2);
            for (int i = 0; i < NC; i++) begin
                start[i] = ($urandom % 6 == 0);
                set_dur(i, int'($urandom % 4));
                cancel[i] = !evt_ready && ($urandom % 20 == 0);
            end
            cycle();
            pk = m_pick();
            n_checks++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b want %b", ecnt, busy, m_busy()); end
            n_checks++; if (evt_valid !== (pk >= 0)) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b", ecnt, evt_valid, pk >= 0); end
            if (pk >= 0) begin
                n_checks++; if (evt_ch !== 2'(pk)) begin n_fail++; $display("FAIL rand_ch: cycle %0d got %0d want %0d", ecnt, evt_ch, pk); end
            end
            n_checks++; if (tick !== tick_exp()) begin n_fail++; $display("FAIL rand_tick: cycle %0d got %b want %b", ecnt, tick, tick_exp()); end
        end
        start = '0;
        cancel = '0;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            m_st[i] = 0;
            m_exp_at[i] = 0;
        end
        test_reset();
        test_single();
        test_stall();
        test_rr();
        test_zero_dur();
        test_cancel();
        test_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
